// File: rtl/spi_cmd_sequencer.sv
// spi_cmd_sequencer
//
// Table-driven controller that walks the single-transaction SPI engine
// through an ordered list of write / read / delay commands (e.g. a DAC
// register init script). The host loads the table, pulses start, and the
// block issues each entry, waits for the engine to finish, checks read data
// against the expected value and reports completion or errors.
//
// Optional feature macro: SPI_SEQ_TIMEOUT_EN
//   defined   -> per-state watchdog (TIMEOUT_CYCLES) raising err_timeout
//   undefined -> no watchdog logic, err_timeout tied to 0
//
// Handshake (engine side): eng_valid is raised in ISSUE and held until a
// cycle with eng_valid && eng_ready; it is dropped in the following cycle.
// Fields on eng_wr_infodata / eng_rd_info / eng_mode_sel / eng_delay_cnt are
// stable from eng_valid rising until the next FETCH. The engine signals it is
// working by dropping eng_ready, and completion by raising it again.
//
// Ports
//   clk_in, rst_n          clock, synchronous active-low reset
//   tbl_wr_en/addr/data    command table write port (ignored while busy)
//   start, abort           run control
//   busy, done             run status (done is a one-cycle pulse)
//   err_mismatch           sticky read-compare error
//   err_timeout            sticky watchdog error
//   err_index              index of the failing entry
//   rd_valid, rd_data      captured read data (pulse / held value)
//   eng_*                  command interface to the SPI engine
//   dbg_state              current FSM state encoding

module spi_cmd_sequencer #(
  parameter int SPI_INFO_LENGTH = 8,
  parameter int SPI_DATA_LENGTH = 8,
  parameter int CMD_DEPTH       = 16,
  parameter int CMD_AW          = 4
`ifdef SPI_SEQ_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES  = 65535
`endif
) (
  input  logic                                       clk_in,
  input  logic                                       rst_n,
  input  logic                                       tbl_wr_en,
  input  logic [CMD_AW-1:0]                          tbl_wr_addr,
  input  logic [2+SPI_INFO_LENGTH+SPI_DATA_LENGTH-1:0] tbl_wr_data,
  input  logic                                       start,
  input  logic                                       abort,
  output logic                                       busy,
  output logic                                       done,
  output logic                                       err_mismatch,
  output logic                                       err_timeout,
  output logic [CMD_AW-1:0]                          err_index,
  output logic                                       rd_valid,
  output logic [SPI_DATA_LENGTH-1:0]                 rd_data,
  output logic [SPI_INFO_LENGTH+SPI_DATA_LENGTH-1:0] eng_wr_infodata,
  output logic [SPI_INFO_LENGTH-1:0]                 eng_rd_info,
  output logic [1:0]                                 eng_mode_sel,
  output logic [15:0]                                eng_delay_cnt,
  output logic                                       eng_valid,
  input  logic                                       eng_ready,
  input  logic [SPI_DATA_LENGTH-1:0]                 eng_rd_data,
  output logic [2:0]                                 dbg_state
);

  localparam int ID = SPI_INFO_LENGTH + SPI_DATA_LENGTH;
  localparam int EW = ID + 2;
  localparam logic [CMD_AW-1:0] LAST_IDX = CMD_AW'(CMD_DEPTH - 1);

  localparam logic [1:0] MODE_RD  = 2'b01;
  localparam logic [1:0] MODE_END = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_ISSUE     = 3'd2,
    S_WAIT_BUSY = 3'd3,
    S_WAIT_IDLE = 3'd4,
    S_NEXT      = 3'd5,
    S_FIN       = 3'd6
  } state_t;

  // Command table: plain register array, deliberately not reset.
  logic [EW-1:0] tbl_q [CMD_DEPTH];

  state_t                state_q;
  logic [CMD_AW-1:0]     idx_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  abort_q;
  logic                  err_mismatch_q;
  logic [CMD_AW-1:0]     err_index_q;
  logic                  rd_valid_q;
  logic [SPI_DATA_LENGTH-1:0] rd_data_q;
  logic [ID-1:0]         eng_wr_infodata_q;
  logic [SPI_INFO_LENGTH-1:0] eng_rd_info_q;
  logic [1:0]            eng_mode_q;
  logic [15:0]           eng_delay_q;
  logic                  eng_valid_q;

  // The table cannot change while busy, so the entry at idx_q stays valid
  // for the whole transaction (used for the expected read value).
  logic [EW-1:0] cur_entry;
  logic [1:0]    cur_mode;
  assign cur_entry = tbl_q[idx_q];
  assign cur_mode  = cur_entry[EW-1:EW-2];

  always_ff @(posedge clk_in) begin
    if (tbl_wr_en && !busy_q) begin
      tbl_q[tbl_wr_addr] <= tbl_wr_data;
    end
  end

`ifdef SPI_SEQ_TIMEOUT_EN
  logic [31:0] wd_q;
  logic        err_timeout_q;
  logic        wd_active;
  assign wd_active = (state_q == S_ISSUE) || (state_q == S_WAIT_BUSY) ||
                     (state_q == S_WAIT_IDLE);
`endif

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      state_q           <= S_IDLE;
      idx_q             <= '0;
      busy_q            <= 1'b0;
      done_q            <= 1'b0;
      abort_q           <= 1'b0;
      err_mismatch_q    <= 1'b0;
      err_index_q       <= '0;
      rd_valid_q        <= 1'b0;
      rd_data_q         <= '0;
      eng_wr_infodata_q <= '0;
      eng_rd_info_q     <= '0;
      eng_mode_q        <= 2'b00;
      eng_delay_q       <= '0;
      eng_valid_q       <= 1'b0;
`ifdef SPI_SEQ_TIMEOUT_EN
      wd_q              <= '0;
      err_timeout_q     <= 1'b0;
`endif
    end else begin
      done_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      // abort is remembered and only acted on between transactions.
      if (busy_q && abort) begin
        abort_q <= 1'b1;
      end
`ifdef SPI_SEQ_TIMEOUT_EN
      // Free-running in the waiting states; every entry into one of them
      // below reloads it with 0.
      if (wd_active) begin
        wd_q <= wd_q + 32'd1;
      end
      if (wd_active && (wd_q == 32'(TIMEOUT_CYCLES - 1))) begin
        eng_valid_q   <= 1'b0;
        err_timeout_q <= 1'b1;
        err_index_q   <= idx_q;
        state_q       <= S_FIN;
      end else
`endif
      begin
        case (state_q)
          S_IDLE: begin
            // start wins over a coincident abort: abort_q is cleared here.
            if (start) begin
              busy_q         <= 1'b1;
              err_mismatch_q <= 1'b0;
              err_index_q    <= '0;
              abort_q        <= 1'b0;
              idx_q          <= '0;
`ifdef SPI_SEQ_TIMEOUT_EN
              err_timeout_q  <= 1'b0;
`endif
              state_q        <= S_FETCH;
            end
          end
          S_FETCH: begin
            if (cur_mode == MODE_END) begin
              state_q <= S_FIN;
            end else begin
              eng_mode_q        <= cur_mode;
              eng_wr_infodata_q <= cur_entry[ID-1:0];
              eng_rd_info_q     <= cur_entry[ID-1:SPI_DATA_LENGTH];
              eng_delay_q       <= cur_entry[15:0];
              eng_valid_q       <= 1'b1;
`ifdef SPI_SEQ_TIMEOUT_EN
              wd_q              <= '0;
`endif
              state_q           <= S_ISSUE;
            end
          end
          S_ISSUE: begin
            if (eng_ready) begin
              eng_valid_q <= 1'b0;
`ifdef SPI_SEQ_TIMEOUT_EN
              wd_q        <= '0;
`endif
              state_q     <= S_WAIT_BUSY;
            end
          end
          S_WAIT_BUSY: begin
            if (!eng_ready) begin
`ifdef SPI_SEQ_TIMEOUT_EN
              wd_q    <= '0;
`endif
              state_q <= S_WAIT_IDLE;
            end
          end
          S_WAIT_IDLE: begin
            if (eng_ready) begin
              if (eng_mode_q == MODE_RD) begin
                rd_data_q  <= eng_rd_data;
                rd_valid_q <= 1'b1;
                if (eng_rd_data != cur_entry[SPI_DATA_LENGTH-1:0]) begin
                  err_mismatch_q <= 1'b1;
                  err_index_q    <= idx_q;
                  state_q        <= S_FIN;
                end else begin
                  state_q <= S_NEXT;
                end
              end else begin
                state_q <= S_NEXT;
              end
            end
          end
          S_NEXT: begin
            if (abort_q || abort || (idx_q == LAST_IDX)) begin
              state_q <= S_FIN;
            end else begin
              idx_q   <= idx_q + 1'b1;
              state_q <= S_FETCH;
            end
          end
          S_FIN: begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            abort_q <= 1'b0;
            state_q <= S_IDLE;
          end
          default: begin
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign busy            = busy_q;
  assign done            = done_q;
  assign err_mismatch    = err_mismatch_q;
  assign err_index       = err_index_q;
  assign rd_valid        = rd_valid_q;
  assign rd_data         = rd_data_q;
  assign eng_wr_infodata = eng_wr_infodata_q;
  assign eng_rd_info     = eng_rd_info_q;
  assign eng_mode_sel    = eng_mode_q;
  assign eng_delay_cnt   = eng_delay_q;
  assign eng_valid       = eng_valid_q;
  assign dbg_state       = state_q;
`ifdef SPI_SEQ_TIMEOUT_EN
  assign err_timeout     = err_timeout_q;
`else
  assign err_timeout     = 1'b0;
`endif

endmodule

// File: tb/tb_spi_cmd_sequencer.sv
`timescale 1ns/1ps
module tb_spi_cmd_sequencer;

  localparam int I  = 8;
  localparam int D  = 8;
  localparam int AW = 4;
  localparam int EW = 2 + I + D;
  localparam int W  = 18;

  // ---------------- clock / reset / DUT ----------------
  logic          clk_in = 1'b0;
  logic          rst_n = 1'b0;
  logic          tbl_wr_en = 1'b0;
  logic [AW-1:0] tbl_wr_addr = '0;
  logic [EW-1:0] tbl_wr_data = '0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          busy, done, err_mismatch, err_timeout, rd_valid, eng_valid;
  logic [AW-1:0] err_index;
  logic [D-1:0]  rd_data;
  logic [I+D-1:0] eng_wr_infodata;
  logic [I-1:0]  eng_rd_info;
  logic [1:0]    eng_mode_sel;
  logic [15:0]   eng_delay_cnt;
  logic          eng_ready = 1'b1;
  logic [D-1:0]  eng_rd_data = '0;
  logic [2:0]    dbg_state;

  always #5 clk_in = ~clk_in;

  spi_cmd_sequencer #(
    .SPI_INFO_LENGTH(I), .SPI_DATA_LENGTH(D), .CMD_DEPTH(16), .CMD_AW(AW)
`ifdef SPI_SEQ_TIMEOUT_EN
    , .TIMEOUT_CYCLES(200)
`endif
  ) dut (
    .clk_in(clk_in), .rst_n(rst_n), .tbl_wr_en(tbl_wr_en), .tbl_wr_addr(tbl_wr_addr),
    .tbl_wr_data(tbl_wr_data), .start(start), .abort(abort), .busy(busy), .done(done),
    .err_mismatch(err_mismatch), .err_timeout(err_timeout), .err_index(err_index),
    .rd_valid(rd_valid), .rd_data(rd_data), .eng_wr_infodata(eng_wr_infodata),
    .eng_rd_info(eng_rd_info), .eng_mode_sel(eng_mode_sel), .eng_delay_cnt(eng_delay_cnt),
    .eng_valid(eng_valid), .eng_ready(eng_ready), .eng_rd_data(eng_rd_data),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] obs_q[$];
  int hs_q[$];
  int rise_q[$];
  int cyc = 0;
  int eng_cnt = 0;
  int busy_len = 12;
  bit hang = 1'b0;
  int done_cnt = 0;
  int rd_cnt = 0;

  // Key of a transaction: mode plus the field that mode actually uses.
  function automatic logic [W-1:0] exp_key(input logic [1:0] m, input logic [7:0] info,
                                           input logic [7:0] data);
    if (m == 2'b01) return {m, info, 8'h00};
    return {m, info, data};
  endfunction

  function automatic logic [W-1:0] obs_key();
    case (eng_mode_sel)
      2'b00:   return {2'b00, eng_wr_infodata};
      2'b01:   return {2'b01, eng_rd_info, 8'h00};
      default: return {eng_mode_sel, eng_delay_cnt};
    endcase
  endfunction

  // Engine model: accepts on valid&&ready, drops ready while "working",
  // raises ready again after busy_len (or the delay count) cycles.
  always @(posedge clk_in) begin
    cyc <= cyc + 1;
    if (!rst_n) begin
      eng_ready <= 1'b1;
      eng_cnt   <= 0;
    end else if (eng_ready && eng_valid) begin
      obs_q.push_back(obs_key());
      hs_q.push_back(cyc);
      eng_ready <= 1'b0;
      eng_cnt   <= (eng_mode_sel == 2'b10) ? int'(eng_delay_cnt) : busy_len;
    end else if (!eng_ready && !hang) begin
      if (eng_cnt == 0) begin
        eng_ready <= 1'b1;
        rise_q.push_back(cyc);
      end else begin
        eng_cnt <= eng_cnt - 1;
      end
    end
  end

  always @(negedge clk_in) begin
    if (done) done_cnt++;
    if (rd_valid) rd_cnt++;
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk_in);
    rst_n = 1'b1;
    @(negedge clk_in);
  endtask

  task automatic load(input int a, input logic [1:0] m, input logic [7:0] info,
                      input logic [7:0] data);
    @(negedge clk_in);
    tbl_wr_en = 1'b1;
    tbl_wr_addr = a[AW-1:0];
    tbl_wr_data = {m, info, data};
    @(negedge clk_in);
    tbl_wr_en = 1'b0;
  endtask

  task automatic clear_sb();
    exp_q.delete(); obs_q.delete(); hs_q.delete(); rise_q.delete();
  endtask

  task automatic pulse_start();
    @(negedge clk_in);
    start = 1'b1;
    @(negedge clk_in);
    start = 1'b0;
  endtask

  task automatic wait_done(input int max, output bit ok, output logic b);
    ok = 1'b0;
    b = 1'bx;
    for (int i = 0; i < max; i++) begin
      @(negedge clk_in);
      if (done) begin
        ok = 1'b1;
        b = busy;
        break;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    checks++;
    if ({busy, done, err_mismatch, err_timeout, rd_valid, eng_valid} !== 6'b0) begin
      failures++;
      $display("FAIL reset_flags: got %b want 000000",
               {busy, done, err_mismatch, err_timeout, rd_valid, eng_valid});
    end
    checks++;
    if ({eng_mode_sel, eng_delay_cnt} !== 18'h0) begin
      failures++;
      $display("FAIL reset_eng_mode_delay: got %h want 0", {eng_mode_sel, eng_delay_cnt});
    end
    checks++;
    if ({eng_wr_infodata, eng_rd_info, rd_data, err_index} !== 36'h0) begin
      failures++;
      $display("FAIL reset_data: got %h want 0", {eng_wr_infodata, eng_rd_info, rd_data, err_index});
    end
    checks++;
    if (dbg_state !== 3'd0) begin
      failures++;
      $display("FAIL reset_state: got %0d want 0", dbg_state);
    end
  endtask

  task automatic test_writes();
    bit ok; logic b; int d0; logic [W-1:0] e, o;
    clear_sb();
    load(0, 2'b00, 8'h12, 8'hA5); exp_q.push_back(exp_key(2'b00, 8'h12, 8'hA5));
    load(1, 2'b00, 8'h34, 8'h5A); exp_q.push_back(exp_key(2'b00, 8'h34, 8'h5A));
    load(2, 2'b11, 8'h00, 8'h00);
    d0 = done_cnt;
    @(negedge clk_in);
    start = 1'b1;
    @(negedge clk_in);   // start sampled: FETCH
    start = 1'b0;
    checks++;
    if ({busy, eng_valid} !== 2'b10) begin
      failures++;
      $display("FAIL writes_latency1: busy,valid got %b want 10", {busy, eng_valid});
    end
    @(negedge clk_in);   // ISSUE
    checks++;
    if (eng_valid !== 1'b1) begin
      failures++;
      $display("FAIL writes_latency2: eng_valid got %b want 1", eng_valid);
    end
    wait_done(2000, ok, b);
    repeat (2) @(negedge clk_in);
    checks++;
    if (!ok || b !== 1'b0) begin
      failures++;
      $display("FAIL writes_done: seen %0d busy_at_done %b want 1/0", ok, b);
    end
    checks++;
    if (done_cnt - d0 != 1 || {err_mismatch, err_timeout} !== 2'b00) begin
      failures++;
      $display("FAIL writes_status: done pulses %0d errs %b want 1/00", done_cnt - d0,
               {err_mismatch, err_timeout});
    end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL writes_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o !== e) begin failures++; $display("FAIL writes_txn: got %h want %h", o, e); end
    end
  endtask

  task automatic test_read_match();
    bit ok; logic b; int r0; logic [W-1:0] e, o;
    clear_sb();
    load(0, 2'b01, 8'h80, 8'h3C); exp_q.push_back(exp_key(2'b01, 8'h80, 8'h3C));
    load(1, 2'b11, 8'h00, 8'h00);
    eng_rd_data = 8'h3C;
    r0 = rd_cnt;
    pulse_start();
    wait_done(2000, ok, b);
    repeat (2) @(negedge clk_in);
    checks++;
    if (!ok || rd_cnt - r0 != 1 || rd_data !== 8'h3C || err_mismatch !== 1'b0) begin
      failures++;
      $display("FAIL read_match: done %0d rd_pulses %0d rd_data %h mism %b want 1/1/3c/0",
               ok, rd_cnt - r0, rd_data, err_mismatch);
    end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL read_match_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o !== e) begin failures++; $display("FAIL read_match_txn: got %h want %h", o, e); end
    end
  endtask

  task automatic test_read_mismatch();
    bit ok; logic b; int d0; logic [W-1:0] e, o;
    clear_sb();
    load(0, 2'b01, 8'h80, 8'h3C); exp_q.push_back(exp_key(2'b01, 8'h80, 8'h3C));
    load(1, 2'b00, 8'h11, 8'h22);  // must never be issued
    load(2, 2'b11, 8'h00, 8'h00);
    eng_rd_data = 8'h3D;
    d0 = done_cnt;
    pulse_start();
    wait_done(2000, ok, b);
    repeat (30) @(negedge clk_in);
    checks++;
    if (!ok || done_cnt - d0 != 1 || err_mismatch !== 1'b1 || err_index !== 4'd0) begin
      failures++;
      $display("FAIL read_mismatch: done %0d pulses %0d mism %b idx %0d want 1/1/1/0",
               ok, done_cnt - d0, err_mismatch, err_index);
    end
    checks++;
    if (rd_data !== 8'h3D) begin
      failures++;
      $display("FAIL read_mismatch_data: got %h want 3d", rd_data);
    end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL read_mismatch_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o !== e) begin failures++; $display("FAIL read_mismatch_txn: got %h want %h", o, e); end
    end
  endtask

  task automatic test_delay();
    bit ok; logic b; logic [W-1:0] e, o; int gap;
    clear_sb();
    load(0, 2'b00, 8'h01, 8'h11); exp_q.push_back(exp_key(2'b00, 8'h01, 8'h11));
    load(1, 2'b10, 8'h00, 8'h05); exp_q.push_back(exp_key(2'b10, 8'h00, 8'h05));
    load(2, 2'b00, 8'h02, 8'h22); exp_q.push_back(exp_key(2'b00, 8'h02, 8'h22));
    load(3, 2'b11, 8'h00, 8'h00);
    pulse_start();
    wait_done(2000, ok, b);
    repeat (2) @(negedge clk_in);
    checks++;
    if (!ok || err_mismatch !== 1'b0) begin
      failures++;
      $display("FAIL delay_done: done %0d mism %b want 1/0 (start clears error)", ok, err_mismatch);
    end
    // Third entry may be handshaken only 4 edges after the delay's ready rise.
    gap = (hs_q.size() >= 3 && rise_q.size() >= 2) ? hs_q[2] - rise_q[1] : -1;
    checks++;
    if (gap != 4) begin
      failures++;
      $display("FAIL delay_gap: got %0d want 4", gap);
    end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL delay_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o !== e) begin failures++; $display("FAIL delay_txn: got %h want %h", o, e); end
    end
  endtask

  task automatic test_abort();
    bit ok; logic b; int d0; bit seen; logic [W-1:0] e, o;
    clear_sb();
    for (int i = 0; i < 4; i++) begin
      load(i, 2'b00, 8'hA0 + 8'(i), 8'(i * 17));
      if (i < 2) exp_q.push_back(exp_key(2'b00, 8'hA0 + 8'(i), 8'(i * 17)));
    end
    load(4, 2'b11, 8'h00, 8'h00);
    d0 = done_cnt;
    pulse_start();
    seen = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk_in);
      if (obs_q.size() >= 2) begin seen = 1'b1; break; end
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL abort_entry1_issue: got %0d txns want 2", obs_q.size());
    end
    abort = 1'b1;
    start = 1'b1;   // start while busy must be ignored
    @(negedge clk_in);
    abort = 1'b0;
    start = 1'b0;
    wait_done(2000, ok, b);
    repeat (40) @(negedge clk_in);
    checks++;
    if (!ok || done_cnt - d0 != 1 || busy !== 1'b0 || eng_valid !== 1'b0) begin
      failures++;
      $display("FAIL abort_done: done %0d pulses %0d busy %b valid %b want 1/1/0/0",
               ok, done_cnt - d0, busy, eng_valid);
    end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL abort_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o !== e) begin failures++; $display("FAIL abort_txn: got %h want %h", o, e); end
    end
  endtask

  task automatic test_back_to_back();
    bit ok; logic b; int d0; int bad_gap; logic [W-1:0] e, o;
    logic [1:0] m; logic [7:0] info, data;
    clear_sb();
    busy_len = 3;
    for (int i = 0; i < 16; i++) begin
      m = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b10;
      info = (m == 2'b10) ? 8'h00 : 8'($urandom_range(0, 255));
      data = (m == 2'b10) ? 8'($urandom_range(1, 6)) : 8'($urandom_range(0, 255));
      load(i, m, info, data);
      exp_q.push_back(exp_key(m, info, data));
    end
    d0 = done_cnt;
    pulse_start();
    repeat (5) @(negedge clk_in);
    tbl_wr_en = 1'b1;      // write while busy: must be ignored
    tbl_wr_addr = 4'd15;
    tbl_wr_data = {2'b11, 16'h0000};
    @(negedge clk_in);
    tbl_wr_en = 1'b0;
    wait_done(4000, ok, b);
    repeat (2) @(negedge clk_in);
    checks++;
    if (!ok || b !== 1'b0 || done_cnt - d0 != 1) begin
      failures++;
      $display("FAIL b2b_done: done %0d busy %b pulses %0d want 1/0/1", ok, b, done_cnt - d0);
    end
    bad_gap = 0;
    for (int i = 0; i + 1 < hs_q.size() && i < rise_q.size(); i++) begin
      if (hs_q[i+1] - rise_q[i] != 4) bad_gap++;
    end
    checks++;
    if (bad_gap != 0) begin
      failures++;
      $display("FAIL b2b_gap: got %0d bad gaps want 0", bad_gap);
    end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL b2b_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o !== e) begin failures++; $display("FAIL b2b_txn: got %h want %h", o, e); end
    end
    busy_len = 12;
  endtask

`ifdef SPI_SEQ_TIMEOUT_EN
  task automatic test_timeout();
    bit ok; logic b; bit seen; int t_cyc; int d0;
    clear_sb();
    load(0, 2'b00, 8'h55, 8'h66);
    load(1, 2'b11, 8'h00, 8'h00);
    hang = 1'b1;
    d0 = done_cnt;
    pulse_start();
    seen = 1'b0;
    t_cyc = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk_in);
      if (err_timeout === 1'b1) begin seen = 1'b1; t_cyc = cyc; break; end
    end
    checks++;
    if (!seen || hs_q.size() < 1 || t_cyc - hs_q[0] != 202 || eng_valid !== 1'b0) begin
      failures++;
      $display("FAIL timeout_flag: seen %0d delta %0d valid %b want 1/202/0", seen,
               (hs_q.size() > 0) ? t_cyc - hs_q[0] : -1, eng_valid);
    end
    wait_done(10, ok, b);
    repeat (2) @(negedge clk_in);
    checks++;
    if (!ok || done_cnt - d0 != 1 || err_timeout !== 1'b1 || err_index !== 4'd0) begin
      failures++;
      $display("FAIL timeout_done: done %0d pulses %0d to %b idx %0d want 1/1/1/0",
               ok, done_cnt - d0, err_timeout, err_index);
    end
    do_reset();
    hang = 1'b0;
    checks++;
    if (err_timeout !== 1'b0) begin
      failures++;
      $display("FAIL timeout_reset: got %b want 0", err_timeout);
    end
  endtask
`endif

  // ---------------- sequence & report ----------------
  initial begin
    do_reset();
    test_reset();
    test_writes();
    test_read_match();
    test_read_mismatch();
    test_delay();
    test_abort();
    test_back_to_back();
`ifdef SPI_SEQ_TIMEOUT_EN
    test_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL global_time_limit: simulation did not complete");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/spi_cmd_sequencer.md
# spi_cmd_sequencer

Table-driven controller that sequences the single-transaction SPI engine (`spi_wr_rd_single`) through an ordered list of write, read and delay commands, such as a DAC register init script. A host loads the command table, pulses `start`, and the block issues each entry through the engine's valid/ready handshake. It waits for each transaction to complete, captures read data and checks it against an expected value. It sits between the host/config logic and the SPI engine, and owns all of the engine's command inputs.

## Interface
- `SPI_INFO_LENGTH`, 8, address/info field width; must match the engine.
- `SPI_DATA_LENGTH`, 8, data field width; must match the engine. `INFO+DATA` must be ≥16.
- `CMD_DEPTH`, 16, number of table entries.
- `CMD_AW`, 4, table address width; `2**CMD_AW` = `CMD_DEPTH`.
- `TIMEOUT_CYCLES`, 65535, watchdog limit in `clk_in` cycles (only with the macro defined).
- `clk_in`  in  1  system clock; the same clock as the engine.
- `rst_n`  in  1  reset: synchronous, active-low; clock `clk_in`.
- `tbl_wr_en`  in  1  table write strobe; ignored while `busy`.
- `tbl_wr_addr`  in  `CMD_AW`  table write address.
- `tbl_wr_data`  in  `2+INFO+DATA`  entry: `[MSB:MSB-1]` mode (00 write, 01 read, 10 delay, 11 end); `[INFO+DATA-1:DATA]` info; `[DATA-1:0]` data (write data / expected read value). For a delay entry, the low 16 bits are the delay count.
- `start`  in  1  one-cycle pulse; begins execution at entry 0; ignored while `busy`.
- `abort`  in  1  stops execution at the next transaction boundary.
- `busy`  out  1  high from `start` acceptance until `done`.
- `done`  out  1  one-cycle pulse at the end of the list, on abort, or on error.
- `err_mismatch`  out  1  sticky; a read value differed from the expected value; cleared by `start`.
- `err_timeout`  out  1  sticky watchdog flag; cleared by `start`; tied 0 without the macro.
- `err_index`  out  `CMD_AW`  index of the first failing entry.
- `rd_valid`  out  1  one-cycle pulse per completed read.
- `rd_data`  out  `DATA`  captured read value, held until the next read.
- `eng_wr_infodata`  out  `INFO+DATA`  engine write word.
- `eng_rd_info`  out  `INFO`  engine read address.
- `eng_mode_sel`  out  2  engine mode select.
- `eng_delay_cnt`  out  16  engine delay count.
- `eng_valid`  out  1  engine `datain_valid`.
- `eng_ready`  in  1  engine `datain_ready`.
- `eng_rd_data`  in  `DATA`  engine `r_rd_data`.

## Operation
- Reset values:
  - All outputs are 0, except `eng_mode_sel` = 2'b00 and `eng_delay_cnt` = 0.
  - The state machine goes to IDLE.
  - Table contents are not reset.
- The table is a register array. It is written only while `busy` = 0.
- State machine states:
  - IDLE: on `start`, set `busy`, clear the error flags, set idx = 0, go to FETCH.
  - FETCH: read the entry at idx.
    - If mode is 11, go to FIN.
    - Otherwise drive the `eng_*` fields from the entry. Fields are registered and held stable until the next FETCH.
    - Go to ISSUE.
  - ISSUE: `eng_valid` = 1. Handshake occurs in a cycle where `eng_valid` && `eng_ready`; then drop `eng_valid` and go to WAIT_BUSY.
  - WAIT_BUSY: wait for `eng_ready` = 0 (engine has left IDLE), then go to WAIT_IDLE.
  - WAIT_IDLE: wait for `eng_ready` = 1 (engine has returned to IDLE). Then:
    - For a read entry, latch `eng_rd_data` into `rd_data`, pulse `rd_valid` and compare against the data field. On mismatch, set `err_mismatch`, record `err_index` and go to FIN.
    - Otherwise go to NEXT.
  - NEXT:
    - If `abort` was seen, or idx = `CMD_DEPTH`-1, go to FIN.
    - Otherwise idx+1, go to FETCH.
  - FIN: pulse `done`, clear `busy`, go to IDLE.
- `abort` is latched in any busy state and acted on in NEXT. A transaction in progress always completes, so the engine is never left mid-frame.
- `start` and `abort` asserted in the same cycle in IDLE: `start` wins, and the abort is discarded.
- If `rst_n` is asserted mid-transaction, the block returns to IDLE with `eng_valid` = 0. The engine is reset by the same `rst_n`.

## Timing
- `start` to `eng_valid` = 1: 2 cycles (IDLE → FETCH → ISSUE).
- `eng_valid` drops in the cycle after the handshake.
- Transaction completion to the next `eng_valid`: 3 cycles (WAIT_IDLE → NEXT → FETCH → ISSUE).
- `rd_valid` is asserted in the cycle after the `eng_ready` rising edge is seen in WAIT_IDLE. `rd_data` is valid in the same cycle.
- `done` is asserted for exactly one cycle. `busy` falls in the same cycle as `done`.
- The engine's serial clock is derived internally (about 101 `clk_in` cycles per bit), so WAIT_BUSY and WAIT_IDLE each last many cycles. There is no fixed bound on them.

## Configuration
- `SPI_SEQ_TIMEOUT_EN` defined:
  - A watchdog counts cycles spent in ISSUE, WAIT_BUSY and WAIT_IDLE; it resets on each state entry.
  - On reaching `TIMEOUT_CYCLES`, drop `eng_valid`, set `err_timeout`, record `err_index` and go to FIN.
- `SPI_SEQ_TIMEOUT_EN` undefined: no counter logic is present, `err_timeout` = 0, and the waits are unbounded.

## Test plan
- Table {write 0x12/0xA5, write 0x34/0x5A, end}, `start`: the engine receives `eng_wr_infodata` 0x12A5 then 0x345A, each with mode 00. `done` pulses once and both errors stay 0.
- Table {read 0x80, expected 0x3C, end} with the engine model returning 0x3C: `rd_valid` pulses once, `rd_data` = 0x3C, `err_mismatch` = 0.
- Same table with the model returning 0x3D: `err_mismatch` = 1, `err_index` = 0, `done` pulses and no further entry is issued.
- Table {write, delay 0x0005, write, end}: the delay entry drives mode 10 with `eng_delay_cnt` = 5, and the third entry is issued only after the engine's ready returns.
- `abort` pulsed during entry 1 of a 4-entry table: entry 1 completes, entry 2 is never issued, and `done` pulses. A `start` pulse while `busy` is ignored.
- With `SPI_SEQ_TIMEOUT_EN` and `TIMEOUT_CYCLES` = 200, the model holds ready low forever: `err_timeout` = 1 at 200 cycles after WAIT_IDLE entry, `eng_valid` = 0 and `done` pulses.
